// File: rtl/ls_bus_bridge_pkg.sv
// Shared types and helpers for the load/store bus bridge: FSM states,
// byte-strobe reduction and doubleword-index to byte-address conversion.
package ls_bus_bridge_pkg;

  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE
  } state_t;

  function automatic logic [SW-1:0] mask_to_strb(input logic [DW-1:0] mask);
    logic [SW-1:0] strb;
    strb = '0;
    for (int i = 0; i < SW; i++) begin
      strb[i] = |mask[8*i +: 8];
    end
    return strb;
  endfunction

  // Top three index bits fall off: byte addresses are 64 bits wide.
  function automatic logic [DW-1:0] index_to_addr(input logic [DW-1:0] idx);
    return {idx[DW-4:0], 3'b000};
  endfunction

endpackage

// File: rtl/ls_mask2strb.sv
// Reduces a byte-granular 64-bit write mask to an 8-bit byte strobe.
// Purely combinational, no latency, no flow control.
module ls_mask2strb
  import ls_bus_bridge_pkg::*;
(
  input  logic [DW-1:0] i_mask,
  output logic [SW-1:0] o_strb
);

  assign o_strb = mask_to_strb(i_mask);

endmodule

// File: rtl/ls_bus_bridge.sv
// Replays one load/store at a time onto a single-beat request/response bus; done pulses
// 3+ cycles after fire. Upstream ready drops for the whole transaction; bus stalls hold REQ.
module ls_bus_bridge
  import ls_bus_bridge_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT  = 255,
  parameter logic [63:0] TIMEOUT_RDATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        opload_index_valid,
  output logic        opload_index_ready,
  input  logic [63:0] opload_index,
  output logic        opload_operation_done,
  output logic [63:0] opload_read_data,
  input  logic        opstore_index_valid,
  output logic        opstore_index_ready,
  input  logic [63:0] opstore_index,
  input  logic [63:0] opstore_write_data,
  input  logic [63:0] opstore_write_mask,
  output logic        opstore_operation_done,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [63:0] bus_req_addr,
  output logic [63:0] bus_req_wdata,
  output logic [7:0]  bus_req_wstrb,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_resp_data,
  output logic        bus_err
);

  localparam int unsigned CNT_W = $clog2(RESP_TIMEOUT + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req_valid;
  logic               r_req_write;
  logic [DW-1:0]      r_req_addr;
  logic [DW-1:0]      r_req_wdata;
  logic [SW-1:0]      r_req_wstrb;
  logic [DW-1:0]      r_rdata;
  logic               r_load_done;
  logic               r_store_done;
  logic               r_err;

  logic               w_idle;
  logic               w_load_fire;
  logic               w_store_fire;
  logic               w_timeout;
  logic               w_stray_resp;
  logic [SW-1:0]      w_store_strb;

  ls_mask2strb u_mask2strb (
    .i_mask (opstore_write_mask),
    .o_strb (w_store_strb)
  );

  // Load wins a tie; the store simply stays pending until the next IDLE.
  assign w_idle       = (r_state == IDLE);
  assign w_load_fire  = w_idle && opload_index_valid;
  assign w_store_fire = w_idle && !opload_index_valid && opstore_index_valid;
  assign w_timeout    = (r_cnt == CNT_W'(RESP_TIMEOUT));
  assign w_stray_resp = bus_resp_valid && (r_state != WAIT_RESP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_valid  <= 1'b0;
      r_req_write  <= 1'b0;
      r_req_addr   <= '0;
      r_req_wdata  <= '0;
      r_req_wstrb  <= '0;
      r_rdata      <= '0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      if (w_stray_resp) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_load_fire) begin
            r_req_write <= 1'b0;
            r_req_addr  <= index_to_addr(opload_index);
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
            r_req_valid <= 1'b1;
            r_state     <= REQ;
          end else if (w_store_fire) begin
            r_req_write <= 1'b1;
            r_req_addr  <= index_to_addr(opstore_index);
            r_req_wdata <= opstore_write_data;
            r_req_wstrb <= w_store_strb;
            r_req_valid <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          r_cnt <= r_cnt + 1'b1;
          // A response landing on the timeout cycle still counts as a real response.
          if (bus_resp_valid) begin
            r_rdata      <= bus_resp_data;
            r_load_done  <= !r_req_write;
            r_store_done <= r_req_write;
            r_state      <= DONE;
          end else if (w_timeout) begin
            r_rdata      <= TIMEOUT_RDATA;
            r_err        <= 1'b1;
            r_load_done  <= !r_req_write;
            r_store_done <= r_req_write;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign opload_index_ready     = w_idle;
  assign opstore_index_ready    = w_idle && !opload_index_valid;
  assign opload_operation_done  = r_load_done;
  assign opstore_operation_done = r_store_done;
  assign opload_read_data       = r_rdata;
  assign bus_req_valid          = r_req_valid;
  assign bus_req_write          = r_req_write;
  assign bus_req_addr           = r_req_addr;
  assign bus_req_wdata          = r_req_wdata;
  assign bus_req_wstrb          = r_req_wstrb;
  assign bus_err                = r_err;

endmodule

// File: tb/tb_ls_bus_bridge.sv
// Self-checking bench for ls_bus_bridge: directed vector table, hand-written
// corner sequences, and randomized transactions against a latency/data model.
module tb_ls_bus_bridge;

  localparam int          TO      = 4;
  localparam logic [63:0] TO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clock;
  logic        reset_n;
  logic        opload_index_valid;
  logic        opload_index_ready;
  logic [63:0] opload_index;
  logic        opload_operation_done;
  logic [63:0] opload_read_data;
  logic        opstore_index_valid;
  logic        opstore_index_ready;
  logic [63:0] opstore_index;
  logic [63:0] opstore_write_data;
  logic [63:0] opstore_write_mask;
  logic        opstore_operation_done;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [63:0] bus_req_addr;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_data;
  logic        bus_err;

  ls_bus_bridge #(
    .RESP_TIMEOUT  (TO),
    .TIMEOUT_RDATA (TO_DATA)
  ) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .opload_index_valid     (opload_index_valid),
    .opload_index_ready     (opload_index_ready),
    .opload_index           (opload_index),
    .opload_operation_done  (opload_operation_done),
    .opload_read_data       (opload_read_data),
    .opstore_index_valid    (opstore_index_valid),
    .opstore_index_ready    (opstore_index_ready),
    .opstore_index          (opstore_index),
    .opstore_write_data     (opstore_write_data),
    .opstore_write_mask     (opstore_write_mask),
    .opstore_operation_done (opstore_operation_done),
    .bus_req_valid          (bus_req_valid),
    .bus_req_ready          (bus_req_ready),
    .bus_req_write          (bus_req_write),
    .bus_req_addr           (bus_req_addr),
    .bus_req_wdata          (bus_req_wdata),
    .bus_req_wstrb          (bus_req_wstrb),
    .bus_resp_valid         (bus_resp_valid),
    .bus_resp_data          (bus_resp_data),
    .bus_err                (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit err_model = 1'b0;

  typedef struct {
    bit          is_store;
    logic [63:0] index;
    logic [63:0] wdata;
    logic [63:0] mask;
    int          req_wait;
    int          resp_wait;
    logic [63:0] resp_data;
    logic [63:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic from the bridge's documented rules.
  function automatic logic [63:0] m_addr(input logic [63:0] idx);
    return idx * 64'd8;
  endfunction

  function automatic logic [7:0] m_strb(input logic [63:0] m);
    logic [7:0] s;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      if (((m >> (8 * b)) & 64'hFF) != 64'd0) s = s | 8'(1 << b);
    end
    return s;
  endfunction

  function automatic int m_latency(input int req_wait, input int resp_wait);
    return 3 + req_wait + ((resp_wait < TO) ? resp_wait : TO);
  endfunction

  function automatic vec_t mk(input bit st, input logic [63:0] idx, input logic [63:0] wd,
                              input logic [63:0] mk_mask, input int rq, input int rs,
                              input logic [63:0] rd, input logic [63:0] ea, input logic [7:0] es,
                              input logic [63:0] er);
    vec_t v;
    v.is_store = st;  v.index = idx;  v.wdata = wd;  v.mask = mk_mask;
    v.req_wait = rq;  v.resp_wait = rs;  v.resp_data = rd;
    v.exp_addr = ea;  v.exp_strb = es;  v.exp_rdata = er;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [63:0] byte_v;
    v.is_store  = 1'($urandom_range(0, 1));
    v.index     = {$urandom, $urandom};
    v.wdata     = {$urandom, $urandom};
    v.mask      = '0;
    for (int b = 0; b < 8; b++) begin
      case ($urandom_range(0, 2))
        0:       byte_v = 64'h00;
        1:       byte_v = 64'hFF;
        default: byte_v = 64'($urandom_range(0, 255));
      endcase
      v.mask = v.mask | (byte_v << (8 * b));
    end
    v.req_wait  = $urandom_range(0, 3);
    v.resp_wait = $urandom_range(0, 6);
    v.resp_data = {$urandom, $urandom};
    v.exp_addr  = m_addr(v.index);
    v.exp_strb  = m_strb(v.mask);
    v.exp_rdata = (v.resp_wait <= TO) ? v.resp_data : TO_DATA;
    return v;
  endfunction

  // Cycle 0 is the fire cycle; called at a negedge, leaves off at the negedge of cycle lat+1.
  task automatic run_txn(input vec_t t, input bit hold, input vec_t nxt, input bit both);
    int  lat;
    int  acc;
    int  rsp;
    bit  tmo;
    bit  err_before;
    lat        = m_latency(t.req_wait, t.resp_wait);
    acc        = 1 + t.req_wait;
    rsp        = acc + 1 + t.resp_wait;
    tmo        = (t.resp_wait > TO);
    err_before = err_model;
    for (int c = 0; c <= lat + 1; c++) begin
      opload_index_valid  = (c == 0) && !t.is_store;
      opstore_index_valid = ((c == 0) && t.is_store) || hold;
      if (c == 0) begin
        if (t.is_store) begin
          opstore_index      = t.index;
          opstore_write_data = t.wdata;
          opstore_write_mask = t.mask;
        end else begin
          opload_index = t.index;
          if (hold) begin
            opstore_index      = nxt.index;
            opstore_write_data = nxt.wdata;
            opstore_write_mask = nxt.mask;
          end
        end
      end
      bus_req_ready  = (c == acc);
      bus_resp_valid = (c == rsp) && !tmo;
      bus_resp_data  = (c == rsp) ? t.resp_data : {$urandom, $urandom};
      #1;
      if (c == 0) begin
        if (t.is_store) chk("store_ready_idle", opstore_index_ready, 1);
        else            chk("load_ready_idle", opload_index_ready, 1);
        if (both)       chk("store_ready_loses_tie", opstore_index_ready, 0);
        chk("err_before", bus_err, err_before);
      end
      if (c == 1) begin
        chk("load_ready_busy", opload_index_ready, 0);
        chk("store_ready_busy", opstore_index_ready, 0);
      end
      if (c >= 1 && c <= acc) begin
        chk("req_valid", bus_req_valid, 1);
        chk("req_write", bus_req_write, t.is_store);
        chk("req_addr", bus_req_addr, t.exp_addr);
        if (t.is_store) begin
          chk("req_wdata", bus_req_wdata, t.wdata);
          chk("req_wstrb", bus_req_wstrb, t.exp_strb);
        end
      end
      if (c > acc && c <= lat) chk("req_valid_dropped", bus_req_valid, 0);
      if (c >= 1) begin
        chk("load_done", opload_operation_done, (c == lat) && !t.is_store);
        chk("store_done", opstore_operation_done, (c == lat) && t.is_store);
      end
      if (c == lat) begin
        err_model = err_model | tmo;
        chk("err_after", bus_err, err_model);
        if (!t.is_store) chk("read_data", opload_read_data, t.exp_rdata);
      end
      if (c == lat + 1) begin
        if (!t.is_store) chk("read_data_hold", opload_read_data, t.exp_rdata);
        chk("load_ready_back", opload_index_ready, 1);
        chk("store_ready_back", opstore_index_ready, 1);
      end
      if (c != lat + 1) begin
        @(posedge clock);
        @(negedge clock);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_load_ready"}, opload_index_ready, 1);
    chk({tag, "_store_ready"}, opstore_index_ready, 1);
    chk({tag, "_req_valid"}, bus_req_valid, 0);
    chk({tag, "_req_write"}, bus_req_write, 0);
    chk({tag, "_req_addr"}, bus_req_addr, 0);
    chk({tag, "_req_wdata"}, bus_req_wdata, 0);
    chk({tag, "_req_wstrb"}, bus_req_wstrb, 0);
    chk({tag, "_load_done"}, opload_operation_done, 0);
    chk({tag, "_store_done"}, opstore_operation_done, 0);
    chk({tag, "_read_data"}, opload_read_data, 0);
  endtask

  vec_t vecs[5];
  vec_t v_ld, v_st, v_to, v_r;

  initial begin
    reset_n             = 1'b0;
    opload_index_valid  = 1'b0;
    opload_index        = '0;
    opstore_index_valid = 1'b0;
    opstore_index       = '0;
    opstore_write_data  = '0;
    opstore_write_mask  = '0;
    bus_req_ready       = 1'b0;
    bus_resp_valid      = 1'b0;
    bus_resp_data       = '0;

    vecs[0] = mk(0, 64'h0000_0000_0600_0001, 64'h0, 64'h0, 0, 0, 64'h1122_3344_5566_7788,
                 64'h0000_0000_3000_0008, 8'h00, 64'h1122_3344_5566_7788);
    vecs[1] = mk(1, 64'h0000_0000_0000_0010, 64'h0000_0000_AB00_0000, 64'h0000_0000_FF00_0000,
                 0, 1, 64'h0, 64'h0000_0000_0000_0080, 8'b0000_1000, 64'h0);
    vecs[2] = mk(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 2, 3, 64'h0123_4567_89AB_CDEF,
                 64'hFFFF_FFFF_FFFF_FFF8, 8'h00, 64'h0123_4567_89AB_CDEF);
    vecs[3] = mk(1, 64'h1234_5678_9ABC_DEF0, 64'h5566_7788_99AA_BBCC, 64'hFF00_0000_0000_0001,
                 5, 0, 64'h0, 64'h91A2_B3C4_D5E6_F780, 8'h81, 64'h0);
    vecs[4] = mk(0, 64'h0, 64'h0, 64'h0, 1, TO, 64'hCAFE_F00D_1234_5678,
                 64'h0, 8'h00, 64'hCAFE_F00D_1234_5678);
    v_ld = mk(0, 64'h20, 64'h0, 64'h0, 0, 0, 64'hA5A5_5A5A_0F0F_F0F0,
              64'h100, 8'h00, 64'hA5A5_5A5A_0F0F_F0F0);
    v_st = mk(1, 64'h21, 64'hFFFF_0000_FFFF_0000, 64'h00FF_0000_0000_FF00, 1, 2, 64'h0,
              64'h108, 8'h42, 64'h0);
    v_to = mk(0, 64'h3, 64'h0, 64'h0, 0, 99, 64'h0, 64'h18, 8'h00, TO_DATA);

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk_reset_outputs("rst");
    chk("rst_err", bus_err, 0);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_req_valid", bus_req_valid, 0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], 1'b0, vecs[i], 1'b0);

    run_txn(v_ld, 1'b1, v_st, 1'b1);
    run_txn(v_st, 1'b0, v_st, 1'b0);

    run_txn(v_to, 1'b0, v_to, 1'b0);

    for (int i = 0; i < 40; i++) begin
      v_r = rand_vec();
      run_txn(v_r, 1'b0, v_r, 1'b0);
    end

    // Reset during WAIT_RESP, then a stray response while idle.
    opload_index_valid = 1'b1;
    opload_index       = 64'h40;
    @(posedge clock);
    @(negedge clock);
    opload_index_valid = 1'b0;
    bus_req_ready      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus_req_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    err_model = 1'b0;
    chk_reset_outputs("mid_rst");
    chk("mid_rst_err", bus_err, 0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'h7777_8888_9999_AAAA;
    @(posedge clock);
    @(negedge clock);
    bus_resp_valid = 1'b0;
    #1;
    chk_reset_outputs("stray");
    chk("stray_err", bus_err, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("stray_no_load_done", opload_operation_done, 0);
      chk("stray_err_sticky", bus_err, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ls_bus_bridge.md
# ls_bus_bridge

Downstream neighbour of the memory stage. Accepts one load or store request at a time on the opload/opstore channels and replays it onto a single-beat, request/response data bus. Returns a one-cycle `*_operation_done` pulse with read data, which is what releases the memory stage's stall. Includes a response timeout so a silent bus cannot hang the pipeline.

## Interface
Parameters:
- RESP_TIMEOUT, 255: max cycles waited in WAIT_RESP before a forced completion; width of the counter is $clog2(RESP_TIMEOUT+1).
- TIMEOUT_RDATA, 64'hDEAD_BEEF_DEAD_BEEF: read data returned on a timed-out load.

Ports:
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- opload_index_valid  in  1  load request valid
- opload_index_ready  out  1  load request accepted
- opload_index  in  64  doubleword index (byte address >> 3)
- opload_operation_done  out  1  one-cycle load completion pulse
- opload_read_data  out  64  full aligned doubleword, valid while done=1
- opstore_index_valid  in  1  store request valid
- opstore_index_ready  out  1  store request accepted
- opstore_index  in  64  doubleword index
- opstore_write_data  in  64  pre-shifted store data
- opstore_write_mask  in  64  bit mask, byte-granular
- opstore_operation_done  out  1  one-cycle store completion pulse
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_req_write  out  1  1=store, 0=load
- bus_req_addr  out  64  byte address = {index[60:0],3'b000}
- bus_req_wdata  out  64  write data
- bus_req_wstrb  out  8  wstrb[i] = |mask[8i+7:8i]
- bus_resp_valid  in  1  response beat (load data or store ack)
- bus_resp_data  in  64  load data
- bus_err  out  1  sticky: timeout or unexpected response

## Operation
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE: opload_index_ready = opstore_index_ready = 1. If a load is valid, it fires. Otherwise, if a store is valid, it fires. Load has priority when both are valid; the loser's ready is forced to 0 in that cycle.
- On fire: latch write flag, address, wdata, and wstrb into registers, then go to REQ.
- REQ: bus_req_valid=1 with the latched fields. On bus_req_ready go to WAIT_RESP and clear the timeout counter.
- WAIT_RESP: the counter increments every cycle.
  - On bus_resp_valid: latch bus_resp_data into the rdata register and go to DONE.
  - Else, when the counter reaches RESP_TIMEOUT: load TIMEOUT_RDATA, set bus_err, and go to DONE.
  - If both occur in the same cycle, the response wins and no error is raised.
- DONE: assert opload_operation_done for a load, or opstore_operation_done for a store, for exactly one cycle. opload_read_data = rdata register. Return to IDLE.
- Ready is 0 in REQ, WAIT_RESP, and DONE. Only one transaction is outstanding at a time.
- bus_resp_valid outside WAIT_RESP is ignored for data and sets bus_err.
- Store wdata is passed through unmodified. Loads always request the full doubleword, and the upstream stage extracts the sub-word.
- bus_err clears only on reset.

## Timing
- Reset values: state=IDLE; both readies=1 (IDLE); bus_req_valid=0, bus_req_write=0, bus_req_addr=0, bus_req_wdata=0, bus_req_wstrb=0; both done=0; opload_read_data=0; bus_err=0; counter=0.
- Minimum latency: fire at T, bus request at T+1 (ready=1), response at T+2, done at T+3. Done never coincides with fire.
- bus_req_* fields are stable while bus_req_valid=1 and bus_req_ready=0.
- opload_read_data holds its last value outside DONE.
- Reset asserted mid-transaction returns to IDLE immediately. The abandoned bus request is dropped and a later stray response only sets bus_err.
- Timeout path: done occurs RESP_TIMEOUT+1 cycles after entering WAIT_RESP.

## Structure
- Shared package: state enum (IDLE/REQ/WAIT_RESP/DONE), mask-to-strobe function, index-to-address function.
- One natural sub-module: `ls_mask2strb` (64-bit mask to 8-bit strobe reduction). Everything else is flat.

## Test plan
- Load, index=0x0600_0001; bus ready at once, resp at +1 with 0x1122334455667788 -> bus_req_addr=0x3000_0008, write=0, opload_operation_done pulses at T+3 with that data.
- Store with mask 0x0000_0000_FF00_0000, data 0x0000_0000_AB00_0000 -> wstrb=8'b0000_1000, wdata passed through, opstore_operation_done one pulse after ack.
- Simultaneous load and store valid in IDLE -> load fires (opstore_index_ready=0), store fires in the cycle after load done.
- bus_req_ready held 0 for 5 cycles -> request fields stable, no done, upstream ready stays 0.
- RESP_TIMEOUT=4 with no response -> done after 5 WAIT cycles, read data = TIMEOUT_RDATA, bus_err=1 and stays 1.
- Reset asserted during WAIT_RESP, then a stray bus_resp_valid in IDLE -> all outputs at reset values, no done, bus_err=1.
